// File: rtl/digi_ota_pkg.sv
// Shared types and helpers for the clocked digital OTA array.
package digi_ota_pkg;

    typedef enum logic [1:0] {
        HOLD,
        SRC,
        SNK
    } ota_state_e;

    function automatic int unsigned acc_mid(input int unsigned w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic int unsigned acc_max(input int unsigned w);
        return (32'd1 << w) - 1;
    endfunction

    localparam int unsigned DEF_ACC_W = 8;
    localparam int unsigned DEF_MID   = acc_mid(DEF_ACC_W);
    localparam int unsigned DEF_MAX   = acc_max(DEF_ACC_W);

    function automatic int clamp_acc(input int v, input int hi);
        if (v < 0)
            return 0;
        else if (v > hi)
            return hi;
        else
            return v;
    endfunction

endpackage

// File: rtl/digi_ota_channel.sv
// One OTA channel: input synchroniser, stability filter, HOLD/SRC/SNK FSM,
// saturating accumulator and hysteretic comparator.
module digi_ota_channel
    import digi_ota_pkg::*;
#(
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned HYST        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             vip,
    input  logic             vin,
    input  logic [3:0]       gm,
    output logic [ACC_W-1:0] acc,
    output logic             out,
    output logic             out_oe,
    output logic             sat
);

    localparam int unsigned      MID_V   = acc_mid(ACC_W);
    localparam int unsigned      MAX_V   = acc_max(ACC_W);
    localparam logic [ACC_W-1:0] ACC_MID = ACC_W'(MID_V);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(MAX_V);
    localparam logic [ACC_W-1:0] HI_TH   = ACC_W'(MID_V + HYST);
    localparam logic [ACC_W-1:0] LO_TH   = ACC_W'(MID_V - HYST);
    localparam logic [3:0]       FILT_N  = 4'(FILT_LEN);

    logic [SYNC_STAGES-1:0] sync_p, sync_n;
    logic [1:0]             s_pair, pair_c, pair_last, pair_nxt;
    logic [3:0]             cnt, cnt_inc, cnt_nxt;
    ota_state_e             state, state_nxt;
    logic [ACC_W-1:0]       acc_nxt;
    logic                   out_nxt;
    int                     step_v;

    assign s_pair = {sync_p[SYNC_STAGES-1], sync_n[SYNC_STAGES-1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_p    <= '0;
            sync_n    <= '0;
            state     <= HOLD;
            pair_c    <= '0;
            pair_last <= '0;
            cnt       <= '0;
        end else if (ena) begin
            sync_p    <= {sync_p[SYNC_STAGES-2:0], vip};
            sync_n    <= {sync_n[SYNC_STAGES-2:0], vin};
            state     <= state_nxt;
            pair_c    <= pair_nxt;
            pair_last <= s_pair;
            cnt       <= cnt_nxt;
        end
    end

    // cnt==0 means no candidate is in flight, so the run starts at 1 whatever pair_last holds
    always_comb begin
        pair_nxt  = pair_c;
        cnt_nxt   = '0;
        cnt_inc   = 4'd1;
        state_nxt = state;
        if (s_pair != pair_c) begin
            if (s_pair == pair_last && cnt != '0)
                cnt_inc = cnt + 4'd1;
            if (cnt_inc == FILT_N)
                pair_nxt = s_pair;
            else
                cnt_nxt = cnt_inc;
        end
        unique case (pair_nxt)
            2'b10:   state_nxt = SRC;
            2'b01:   state_nxt = SNK;
            default: state_nxt = HOLD;
        endcase
    end

    always_comb begin
        step_v  = 0;
        acc_nxt = acc;
        unique case (state)
            SRC: begin
                step_v  = int'(acc) + int'(gm);
                acc_nxt = ACC_W'(clamp_acc(step_v, int'(MAX_V)));
            end
            SNK: begin
                step_v  = int'(acc) - int'(gm);
                acc_nxt = ACC_W'(clamp_acc(step_v, int'(MAX_V)));
            end
            default: acc_nxt = acc;
        endcase
        out_nxt = out;
        if (acc >= HI_TH)
            out_nxt = 1'b1;
        else if (acc <= LO_TH)
            out_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= ACC_MID;
            out    <= 1'b0;
            out_oe <= 1'b0;
            sat    <= 1'b0;
        end else if (ena) begin
            acc    <= acc_nxt;
            out    <= out_nxt;
            out_oe <= (state_nxt != HOLD);
            sat    <= (acc_nxt == '0) || (acc_nxt == ACC_MAX);
        end
    end

endmodule

// File: rtl/digi_ota_array.sv
// Multi-channel clocked digital OTA with a registered accumulator monitor.
module digi_ota_array
    import digi_ota_pkg::*;
#(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned ACC_W       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 4,
    parameter int unsigned HYST        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic [N_CH-1:0]  vip,
    input  logic [N_CH-1:0]  vin,
    input  logic [3:0]       gm,
    input  logic [1:0]       ch_sel,
    output logic [N_CH-1:0]  out,
    output logic [N_CH-1:0]  out_oe,
    output logic [N_CH-1:0]  sat,
    output logic [ACC_W-1:0] acc_mon
);

    logic [ACC_W-1:0] acc_ch [N_CH];
    logic [ACC_W-1:0] acc_mon_nxt;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        digi_ota_channel #(
            .ACC_W       (ACC_W),
            .SYNC_STAGES (SYNC_STAGES),
            .FILT_LEN    (FILT_LEN),
            .HYST        (HYST)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .ena    (ena),
            .vip    (vip[g]),
            .vin    (vin[g]),
            .gm     (gm),
            .acc    (acc_ch[g]),
            .out    (out[g]),
            .out_oe (out_oe[g]),
            .sat    (sat[g])
        );
    end

    // Selectors beyond the last channel fall through to zero
    always_comb begin
        acc_mon_nxt = '0;
        for (int unsigned i = 0; i < N_CH; i++)
            if (ch_sel == 2'(i))
                acc_mon_nxt = acc_ch[i];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_mon <= '0;
        else if (ena)
            acc_mon <= acc_mon_nxt;
    end

endmodule

// File: tb/tb_digi_ota_array.sv
// Directed self-checking bench for digi_ota_array (defaults, gm=4).
module tb_digi_ota_array;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [2:0] vip, vin;
    logic [3:0] gm;
    logic [1:0] ch_sel;
    logic [2:0] out, out_oe, sat;
    logic [7:0] acc_mon;

    int n_cmp = 0;
    int n_err = 0;

    digi_ota_array dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .vip     (vip),
        .vin     (vin),
        .gm      (gm),
        .ch_sel  (ch_sel),
        .out     (out),
        .out_oe  (out_oe),
        .sat     (sat),
        .acc_mon (acc_mon)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Asserts reset between clock edges, checks the reset values, releases after the next edge
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        vip   = '0;
        vin   = '0;
        ena   = 1'b1;
        #1;
        chk({tag, "_rst_acc_mon"}, int'(acc_mon), 0);
        chk({tag, "_rst_out"},     int'(out),     0);
        chk({tag, "_rst_oe"},      int'(out_oe),  0);
        chk({tag, "_rst_sat"},     int'(sat),     0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        ena    = 1'b1;
        vip    = '0;
        vin    = '0;
        gm     = 4'd4;
        ch_sel = 2'd0;
        #12;
        rst_n  = 1'b1;

        // 1: reset values, then monitor shows MID
        do_reset("t1");
        tick();
        chk("t1_acc_mon_mid", int'(acc_mon), 128);

        // 2: ch0 source, latency and ramp
        vip[0] = 1'b1;
        repeat (5) tick();
        chk("t2_oe_before", int'(out_oe[0]), 0);
        tick();
        chk("t2_oe_rise", int'(out_oe[0]), 1);
        chk("t2_acc_hold", int'(acc_mon), 128);
        repeat (2) tick();
        chk("t2_acc132", int'(acc_mon), 132);
        tick();
        chk("t2_acc136", int'(acc_mon), 136);
        tick();
        chk("t2_acc140", int'(acc_mon), 140);
        chk("t2_out_low", int'(out[0]), 0);
        tick();
        chk("t2_acc144", int'(acc_mon), 144);
        chk("t2_out_high", int'(out[0]), 1);

        // reset mid-ramp
        do_reset("t2m");
        tick();
        chk("t2m_acc_mon", int'(acc_mon), 128);

        // 3: short glitch is rejected
        do_reset("t3");
        vip[0] = 1'b1;
        repeat (3) tick();
        vip[0] = 1'b0;
        repeat (10) tick();
        chk("t3_oe", int'(out_oe[0]), 0);
        chk("t3_acc", int'(acc_mon), 128);

        // 4: saturation then reverse
        do_reset("t4");
        vip[0] = 1'b1;
        repeat (37) tick();
        chk("t4_sat_pre", int'(sat[0]), 0);
        tick();
        chk("t4_acc252", int'(acc_mon), 252);
        chk("t4_sat", int'(sat[0]), 1);
        tick();
        chk("t4_acc255", int'(acc_mon), 255);
        chk("t4_out", int'(out[0]), 1);
        vip[0] = 1'b0;
        vin[0] = 1'b1;
        repeat (6) tick();
        chk("t4_oe_kept", int'(out_oe[0]), 1);
        chk("t4_sat_kept", int'(sat[0]), 1);
        tick();
        chk("t4_sat_clear", int'(sat[0]), 0);
        tick();
        chk("t4_acc251", int'(acc_mon), 251);
        repeat (34) tick();
        chk("t4_acc115", int'(acc_mon), 115);
        chk("t4_out_still1", int'(out[0]), 1);
        tick();
        chk("t4_acc111", int'(acc_mon), 111);
        chk("t4_out_fall", int'(out[0]), 0);

        // 5: freeze mid-ramp
        do_reset("t5");
        vip[0] = 1'b1;
        repeat (9) tick();
        chk("t5_acc136", int'(acc_mon), 136);
        ena = 1'b0;
        repeat (10) tick();
        chk("t5_frz_acc", int'(acc_mon), 136);
        chk("t5_frz_oe", int'(out_oe[0]), 1);
        chk("t5_frz_out", int'(out[0]), 0);
        ena = 1'b1;
        tick();
        chk("t5_acc140", int'(acc_mon), 140);
        tick();
        chk("t5_acc144", int'(acc_mon), 144);
        chk("t5_out", int'(out[0]), 1);
        tick();
        chk("t5_acc148", int'(acc_mon), 148);

        // 5b: filter count survives ena=0
        do_reset("t5b");
        vip[0] = 1'b1;
        repeat (3) tick();
        ena = 1'b0;
        repeat (5) tick();
        chk("t5b_frz_oe", int'(out_oe[0]), 0);
        ena = 1'b1;
        repeat (2) tick();
        chk("t5b_oe_pre", int'(out_oe[0]), 0);
        tick();
        chk("t5b_oe_rise", int'(out_oe[0]), 1);

        // 6: independent channels and monitor select
        do_reset("t6");
        vip = 3'b010;
        vin = 3'b100;
        repeat (6) tick();
        chk("t6_oe", int'(out_oe), 6);
        repeat (6) tick();
        ch_sel = 2'd0;
        tick();
        chk("t6_mon0", int'(acc_mon), 128);
        ch_sel = 2'd1;
        tick();
        chk("t6_mon1", int'(acc_mon), 156);
        ch_sel = 2'd2;
        tick();
        chk("t6_mon2", int'(acc_mon), 96);
        ch_sel = 2'd3;
        tick();
        chk("t6_mon3", int'(acc_mon), 0);
        chk("t6_out", int'(out), 2);
        chk("t6_oe_end", int'(out_oe), 6);
        chk("t6_sat", int'(sat), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
